ysyx_22040365_seq_ctrl: RTL

YSYX_22040365_SEQ_CTRL -- requirements
Module: ysyx_22040365_seq_ctrl

---
 rtl/ysyx_22040365_seq_ctrl_pkg.sv | 21 ++
 rtl/ysyx_22040365_seq_ctrl.sv | 128 ++++++++++++
 2 files changed

// File: rtl/ysyx_22040365_seq_ctrl_pkg.sv
// Shared state encoding and halt-cause codes for the instruction sequencer.
// Anything that decodes halt_cause should import these rather than hard-code the numbers.
package ysyx_22040365_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } seq_state_e;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_EBREAK  = 2'd1;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

  localparam int TIMEOUT_W = 32;

endpackage

// File: rtl/ysyx_22040365_seq_ctrl.sv
// Multi-cycle instruction sequencer: IDLE -> FETCH -> DECODE -> EXEC -> WB -> FETCH, with a sticky HALT
// entered on ebreak, an illegal instruction, or a fetch that waits too long for instruction memory.
module ysyx_22040365_seq_ctrl
  import ysyx_22040365_seq_ctrl_pkg::*;
#(
  parameter logic [63:0] RESET_PC      = 64'h0000_0000_8000_0000,
  parameter int unsigned FETCH_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  input  logic        is_ebreak,
  input  logic        is_illegal,
  input  logic [63:0] a0_data,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  output logic [31:0] inst,
  output logic        ren_rs1,
  output logic        wen_rd,
  output logic [63:0] pc,
  output logic        halt,
  output logic [1:0]  halt_cause,
  output logic [63:0] halt_code,
  output logic [63:0] retire_cnt
);

  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LIM = TIMEOUT_W'(FETCH_TIMEOUT);

  seq_state_e           r_state;
  seq_state_e           w_nextState;
  logic [63:0]          r_pc;
  logic [31:0]          r_inst;
  logic [63:0]          r_retireCnt;
  logic [1:0]           r_haltCause;
  logic [63:0]          r_haltCode;
  logic [TIMEOUT_W-1:0] r_timeoutCnt;
  logic [TIMEOUT_W-1:0] w_timeoutInc;

  assign w_timeoutInc = r_timeoutCnt + 1'b1;

  // A returning rvalid always beats the timeout that would expire in the same cycle.
  always_comb begin
    w_nextState = r_state;
    imem_req    = 1'b0;
    ren_rs1     = 1'b0;
    wen_rd      = 1'b0;
    case (r_state)
      S_IDLE:   w_nextState = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_rvalid)
          w_nextState = S_DECODE;
        else if (w_timeoutInc >= TIMEOUT_LIM)
          w_nextState = S_HALT;
      end
      S_DECODE: begin
        ren_rs1 = 1'b1;
        if (is_ebreak || is_illegal)
          w_nextState = S_HALT;
        else
          w_nextState = S_EXEC;
      end
      S_EXEC: begin
        ren_rs1     = 1'b1;
        w_nextState = S_WB;
      end
      S_WB: begin
        wen_rd      = 1'b1;
        w_nextState = S_FETCH;
      end
      S_HALT:   w_nextState = S_HALT;
      default:  w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_inst       <= '0;
      r_retireCnt  <= '0;
      r_haltCause  <= CAUSE_NONE;
      r_haltCode   <= '0;
      r_timeoutCnt <= '0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        S_IDLE: r_timeoutCnt <= '0;
        S_FETCH: begin
          if (imem_rvalid) begin
            r_inst <= imem_rdata;
          end else begin
            r_timeoutCnt <= w_timeoutInc;
            if (w_nextState == S_HALT) begin
              r_haltCause <= CAUSE_TIMEOUT;
              r_haltCode  <= '0;
            end
          end
        end
        S_DECODE: begin
          if (is_ebreak) begin
            r_haltCause <= CAUSE_EBREAK;
            r_haltCode  <= a0_data;
          end else if (is_illegal) begin
            r_haltCause <= CAUSE_ILLEGAL;
            r_haltCode  <= '0;
          end
        end
        S_WB: begin
          r_pc         <= r_pc + 64'd4;
          r_retireCnt  <= r_retireCnt + 64'd1;
          r_timeoutCnt <= '0;
        end
        default: ;
      endcase
    end
  end

  assign imem_addr  = r_pc;
  assign pc         = r_pc;
  assign inst       = r_inst;
  assign retire_cnt = r_retireCnt;
  assign halt       = (r_state == S_HALT);
  assign halt_cause = r_haltCause;
  assign halt_code  = r_haltCode;

endmodule
